// File: rtl/ysyx_23060096_imem_resp.sv
// Instruction-memory responder: valid/ready fetch port with fixed LATENCY and a loader write port.
// Optional YSYX_23060096_IMEM_EBREAK_DET_EN adds a sticky ebreak_hit output that stalls further fetches.
module ysyx_23060096_imem_resp #(
   parameter int unsigned DEPTH   = 1024,
   parameter logic [31:0] BASE    = 32'h8000_0000,
   parameter int unsigned LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   input  logic        wr_en,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data
`ifdef YSYX_23060096_IMEM_EBREAK_DET_EN
   ,
   output logic        ebreak_hit
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   // Decode a byte address into {in-range-and-aligned, word index}.
   function automatic logic [AW:0] decode(input logic [31:0] addr);
      logic [31:0] off;
      logic        ok;
      off = addr - BASE;
      ok  = (addr[1:0] == 2'b00) && (addr >= BASE) && ((off >> 2) < 32'(DEPTH));
      return {ok, AW'(off >> 2)};
   endfunction

   logic [31:0]   mem [DEPTH];
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic [31:0]   data_q;
   logic          err_q;
   logic [AW:0]   req_dec, wr_dec;
   logic          accept;

   assign req_dec = decode(req_addr);
   assign wr_dec  = decode(wr_addr);

`ifdef YSYX_23060096_IMEM_EBREAK_DET_EN
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   logic ebreak_q;

   assign req_ready  = (state_q == IDLE) && !ebreak_q;
   assign ebreak_hit = ebreak_q;

   always_ff @(posedge clk) begin
      if (rst)
         ebreak_q <= 1'b0;
      else if (rsp_valid && rsp_ready && !err_q && (data_q == EBREAK))
         ebreak_q <= 1'b1;
   end
`else
   assign req_ready = (state_q == IDLE);
`endif

   assign accept    = req_valid && req_ready;
   assign rsp_valid = (state_q == RESP);
   assign rsp_data  = data_q;
   assign rsp_err   = err_q;

   // Loader port: independent of the FSM, bad addresses dropped.
   always_ff @(posedge clk) begin
      if (wr_en && wr_dec[AW])
         mem[wr_dec[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept)
               state_d = (LATENCY == 1) ? RESP : WAIT;
         end
         WAIT: begin
            if (cnt_q == '0)
               state_d = RESP;
         end
         RESP: begin
            if (rsp_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else if (accept)
         cnt_q <= CNT_INIT;
      else if ((state_q == WAIT) && (cnt_q != '0))
         cnt_q <= cnt_q - 1'b1;
   end

   // Read happens on the accept edge, so a same-edge loader write is not seen.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         err_q  <= 1'b0;
      end else if (accept) begin
         err_q  <= !req_dec[AW];
         data_q <= req_dec[AW] ? mem[req_dec[AW-1:0]] : 32'h0;
      end
   end

endmodule

// File: tb/tb_ysyx_23060096_imem_resp.sv
// Bench for ysyx_23060096_imem_resp: two instances (LATENCY 1 and 3) driven by a vector table,
// hand-written corner sequences and random fetches checked against an array model.
module tb_ysyx_23060096_imem_resp;

   localparam int DEPTH = 16;
   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid [2];
   logic        req_ready [2];
   logic [31:0] req_addr  [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_data  [2];
   logic        rsp_err   [2];
   logic        wr_en     [2];
   logic [31:0] wr_addr   [2];
   logic [31:0] wr_data   [2];
`ifdef YSYX_23060096_IMEM_EBREAK_DET_EN
   logic        ebreak_hit [2];
`endif

   int checks = 0;
   int failures = 0;
   int lat [2] = '{1, 3};
   logic [31:0] mdl [2][DEPTH];

   always #5 clk = ~clk;

   ysyx_23060096_imem_resp #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
      .rsp_err(rsp_err[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0])
`ifdef YSYX_23060096_IMEM_EBREAK_DET_EN
      , .ebreak_hit(ebreak_hit[0])
`endif
   );

   ysyx_23060096_imem_resp #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(3)) dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
      .rsp_err(rsp_err[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1])
`ifdef YSYX_23060096_IMEM_EBREAK_DET_EN
      , .ebreak_hit(ebreak_hit[1])
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkb(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a plain word array updated by the address rules.
   function automatic bit addr_valid(input logic [31:0] a);
      logic [63:0] x;
      x = {32'h0, a};
      return (a[1:0] == 2'b00) && (x >= {32'h0, BASE}) &&
             (x <= {32'h0, BASE} + 64'(4 * DEPTH - 4));
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - BASE) / 4);
   endfunction

   function automatic logic [31:0] exp_data(input int d, input logic [31:0] a);
      return addr_valid(a) ? mdl[d][widx(a)] : 32'h0;
   endfunction

   task automatic mdl_write(input int d, input logic [31:0] a, input logic [31:0] v);
      if (addr_valid(a))
         mdl[d][widx(a)] = v;
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 5))
         0, 1, 2: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
         3:       return BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
         4:       return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
         default: return BASE - 32'(4 * $urandom_range(1, 4));
      endcase
   endfunction

   // All tasks start and end on a falling edge.
   task automatic wr(input int d, input logic [31:0] a, input logic [31:0] v);
      wr_en[d] = 1'b1; wr_addr[d] = a; wr_data[d] = v;
      @(negedge clk);
      wr_en[d] = 1'b0;
      mdl_write(d, a, v);
   endtask

   task automatic do_fetch(input int d, input logic [31:0] a, input logic [31:0] ed,
                           input logic ee, input int stall, input bit w,
                           input logic [31:0] wa, input logic [31:0] wd, input logic rdy_after);
      int n;
      n = 0;
      while (!req_ready[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chkb($sformatf("d%0d ready_before_req", d), req_ready[d], 1'b1);
      req_valid[d] = 1'b1; req_addr[d] = a; rsp_ready[d] = 1'b0;
      if (w) begin
         wr_en[d] = 1'b1; wr_addr[d] = wa; wr_data[d] = wd;
      end
      @(negedge clk);
      req_valid[d] = 1'b0; wr_en[d] = 1'b0;
      if (w) mdl_write(d, wa, wd);
      for (int k = 1; k < lat[d]; k++) begin
         chkb($sformatf("d%0d wait_valid k=%0d", d, k), rsp_valid[d], 1'b0);
         chkb($sformatf("d%0d wait_ready k=%0d", d, k), req_ready[d], 1'b0);
         @(negedge clk);
      end
      chkb($sformatf("d%0d rsp_valid a=%h", d, a), rsp_valid[d], 1'b1);
      chk($sformatf("d%0d rsp_data a=%h", d, a), rsp_data[d], ed);
      chkb($sformatf("d%0d rsp_err a=%h", d, a), rsp_err[d], ee);
      chkb($sformatf("d%0d resp_ready a=%h", d, a), req_ready[d], 1'b0);
      for (int s = 0; s < stall; s++) begin
         req_valid[d] = 1'b1; req_addr[d] = ~a;
         @(negedge clk);
         chkb($sformatf("d%0d stall_valid s=%0d", d, s), rsp_valid[d], 1'b1);
         chk($sformatf("d%0d stall_data s=%0d", d, s), rsp_data[d], ed);
         chkb($sformatf("d%0d stall_err s=%0d", d, s), rsp_err[d], ee);
         chkb($sformatf("d%0d stall_ready s=%0d", d, s), req_ready[d], 1'b0);
      end
      req_valid[d] = 1'b0; rsp_ready[d] = 1'b1;
      @(negedge clk);
      rsp_ready[d] = 1'b0;
      chkb($sformatf("d%0d after_valid a=%h", d, a), rsp_valid[d], 1'b0);
      chkb($sformatf("d%0d after_ready a=%h", d, a), req_ready[d], rdy_after);
      chk($sformatf("d%0d after_data a=%h", d, a), rsp_data[d], ed);
   endtask

   typedef struct {
      int          d;
      logic [31:0] a;
      bit          w;
      logic [31:0] wa;
      logic [31:0] wd;
      logic [31:0] ed;
      logic        ee;
      int          stall;
   } vec_t;

   vec_t tbl [13];

   initial begin
      int d, nw, n;
      bit w;
      logic [31:0] a, e, wa, wd;
      logic ee;

      tbl[0]  = '{0, 32'h8000_0000, 0, 32'h0, 32'h0, 32'h0000_0413, 1'b0, 0};
      tbl[1]  = '{1, 32'h8000_0004, 0, 32'h0, 32'h0, 32'h00A0_0093, 1'b0, 0};
      tbl[2]  = '{0, 32'h8000_0002, 0, 32'h0, 32'h0, 32'h0,         1'b1, 0};
      tbl[3]  = '{0, 32'h7FFF_FFFC, 0, 32'h0, 32'h0, 32'h0,         1'b1, 0};
      tbl[4]  = '{1, 32'h8000_0002, 0, 32'h0, 32'h0, 32'h0,         1'b1, 2};
      tbl[5]  = '{0, 32'h8000_0004, 0, 32'h0, 32'h0, 32'h00A0_0093, 1'b0, 5};
      tbl[6]  = '{1, 32'h8000_003C, 0, 32'h0, 32'h0, 32'hC0DE_000F, 1'b0, 0};
      tbl[7]  = '{0, 32'h8000_0040, 0, 32'h0, 32'h0, 32'h0,         1'b1, 0};
      tbl[8]  = '{0, 32'h8000_0000, 0, 32'h0, 32'h0, 32'h0000_0413, 1'b0, 0};
      tbl[9]  = '{0, 32'h8000_0008, 1, 32'h8000_0008, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 0};
      tbl[10] = '{0, 32'h8000_0008, 0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 0};
      tbl[11] = '{1, 32'h8000_0008, 1, 32'h8000_0008, 32'hCAFE_F00D, 32'h1111_1111, 1'b0, 0};
      tbl[12] = '{1, 32'h8000_0008, 0, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0, 1};

      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0; req_addr[i] = '0; rsp_ready[i] = 1'b0;
         wr_en[i] = 1'b0; wr_addr[i] = '0; wr_data[i] = '0;
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chkb($sformatf("d%0d reset req_ready", i), req_ready[i], 1'b1);
         chkb($sformatf("d%0d reset rsp_valid", i), rsp_valid[i], 1'b0);
         chk($sformatf("d%0d reset rsp_data", i), rsp_data[i], 32'h0);
         chkb($sformatf("d%0d reset rsp_err", i), rsp_err[i], 1'b0);
`ifdef YSYX_23060096_IMEM_EBREAK_DET_EN
         chkb($sformatf("d%0d reset ebreak_hit", i), ebreak_hit[i], 1'b0);
`endif
      end
      rst = 1'b0;

      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < DEPTH; j++)
            wr(i, BASE + 32'(4 * j), {16'hC0DE, 16'(j)});
         wr(i, 32'h8000_0000, 32'h0000_0413);
         wr(i, 32'h8000_0004, 32'h00A0_0093);
         wr(i, 32'h8000_0008, 32'h1111_1111);
         wr(i, 32'h8000_0005, 32'hBAD0_BAD0);
         wr(i, 32'h8000_0040, 32'hBAD1_BAD1);
         wr(i, 32'h7FFF_FFFC, 32'hBAD2_BAD2);
      end

      for (int i = 0; i < 13; i++)
         do_fetch(tbl[i].d, tbl[i].a, tbl[i].ed, tbl[i].ee, tbl[i].stall,
                  tbl[i].w, tbl[i].wa, tbl[i].wd, 1'b1);

      // Write to the word of a pending response while waiting: response keeps the old word.
      req_valid[1] = 1'b1; req_addr[1] = 32'h8000_0008;
      @(negedge clk);
      req_valid[1] = 1'b0;
      wr_en[1] = 1'b1; wr_addr[1] = 32'h8000_0008; wr_data[1] = 32'h1234_5678;
      @(negedge clk);
      wr_en[1] = 1'b0;
      mdl_write(1, 32'h8000_0008, 32'h1234_5678);
      n = 0;
      while (!rsp_valid[1] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chkb("pending_write rsp_valid", rsp_valid[1], 1'b1);
      chk("pending_write rsp_data", rsp_data[1], 32'hCAFE_F00D);
      rsp_ready[1] = 1'b1;
      @(negedge clk);
      rsp_ready[1] = 1'b0;
      do_fetch(1, 32'h8000_0008, 32'h1234_5678, 1'b0, 0, 0, 32'h0, 32'h0, 1'b1);

      // Reset while dut1 waits and dut0 presents a response: both responses vanish.
      req_valid[0] = 1'b1; req_addr[0] = 32'h8000_0004;
      req_valid[1] = 1'b1; req_addr[1] = 32'h8000_0004;
      @(negedge clk);
      req_valid[0] = 1'b0; req_valid[1] = 1'b0;
      chkb("midrst d0 presented", rsp_valid[0], 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 2; i++)
            chkb($sformatf("midrst d%0d rsp_valid k=%0d", i, k), rsp_valid[i], 1'b0);
         @(negedge clk);
      end
      for (int i = 0; i < 2; i++) begin
         chkb($sformatf("midrst d%0d req_ready", i), req_ready[i], 1'b1);
         chk($sformatf("midrst d%0d rsp_data", i), rsp_data[i], 32'h0);
      end

      for (int it = 0; it < 120; it++) begin
         d = int'($urandom_range(0, 1));
         nw = int'($urandom_range(0, 2));
         for (int k = 0; k < nw; k++)
            wr(d, rand_addr(), $urandom);
         a  = rand_addr();
         e  = exp_data(d, a);
         ee = !addr_valid(a);
         w  = ($urandom_range(0, 2) == 0);
         wa = ($urandom_range(0, 1) == 1) ? a : rand_addr();
         wd = $urandom;
         do_fetch(d, a, e, ee, int'($urandom_range(0, 3)), w, wa, wd, 1'b1);
      end

`ifdef YSYX_23060096_IMEM_EBREAK_DET_EN
      wr(0, 32'h8000_000C, 32'h0010_0073);
      do_fetch(0, 32'h8000_000C, 32'h0010_0073, 1'b0, 0, 0, 32'h0, 32'h0, 1'b0);
      chkb("ebreak_hit set", ebreak_hit[0], 1'b1);
      req_valid[0] = 1'b1; req_addr[0] = 32'h8000_0000;
      repeat (3) @(negedge clk);
      chkb("ebreak stall ready", req_ready[0], 1'b0);
      chkb("ebreak stall valid", rsp_valid[0], 1'b0);
      req_valid[0] = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chkb("ebreak rst hit", ebreak_hit[0], 1'b0);
      chkb("ebreak rst ready", req_ready[0], 1'b1);
      chkb("ebreak rst valid", rsp_valid[0], 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
